// File: rtl/ram_copy_engine.sv
// ram_copy_engine: moves len words RAM_X->RAM_Y or fills RAM_Y with a constant, start/busy/done/abort handshake
//   clk, rst_n               : clock (logic on negedge), asynchronous active-low reset
//   start, mode, abort       : request, 0=copy 1=fill, terminate active transfer
//   src_base, dst_base, len  : first X address, first Y address, word count 0..2**ADDR_WIDTH
//   fill_value               : fill data
//   RAM_X_*                  : read-only port of the source SRAM
//   RAM_Y_*                  : write port of the destination SRAM
//   busy, done               : transfer in progress, one-cycle end pulse
module ram_copy_engine #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] RAM_X_Do,
    output logic                  RAM_X_EN,
    output logic [WE_WIDTH-1:0]   RAM_X_WE,
    output logic [ADDR_WIDTH-1:0] RAM_X_A,
    output logic                  RAM_Y_EN,
    output logic [WE_WIDTH-1:0]   RAM_Y_WE,
    output logic [ADDR_WIDTH-1:0] RAM_Y_A,
    output logic [DATA_WIDTH-1:0] RAM_Y_Di,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, COPY, FILL, FINISH} state_t;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_src, w_src, r_dst, w_dst, r_x_a, w_x_a, r_y_a, w_y_a;
    logic [ADDR_WIDTH-1:0] w_cnt_lo;
    logic [ADDR_WIDTH:0]   r_len, w_len, r_cnt, w_cnt, w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_fill, w_fill, r_y_di, w_y_di;
    logic                  r_x_en, w_x_en, r_y_en, w_y_en, r_busy, w_busy, r_done, w_done;
    assign w_cnt_lo  = r_cnt[ADDR_WIDTH-1:0];
    assign w_cnt_inc = r_cnt + CNT_ONE;
    // The counter is one bit wider than an address so len=2**ADDR_WIDTH is distinct from 0.
    // In COPY, r_cnt counts read cycles; the write side trails it by one (address r_cnt-1).
    always_comb begin
        w_state = r_state;
        w_src   = r_src;
        w_dst   = r_dst;
        w_len   = r_len;
        w_fill  = r_fill;
        w_cnt   = r_cnt;
        w_x_a   = r_x_a;
        w_y_a   = r_y_a;
        w_y_di  = r_y_di;
        w_x_en  = 1'b0;
        w_y_en  = 1'b0;
        w_busy  = r_busy;
        w_done  = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_src   = src_base;
                w_dst   = dst_base;
                w_len   = len;
                w_fill  = fill_value;
                w_cnt   = '0;
                w_busy  = 1'b1;
                w_state = (len == '0) ? FINISH : (mode ? FILL : COPY);
            end
            COPY: if (abort) begin
                w_state = FINISH;
            end else begin
                w_x_en  = r_cnt < r_len;
                w_x_a   = r_src + w_cnt_lo;
                w_y_en  = r_cnt != '0;
                w_y_a   = r_dst + w_cnt_lo - ADDR_ONE;
                w_y_di  = RAM_X_Do;
                w_cnt   = w_cnt_inc;
                w_state = (r_cnt == r_len) ? FINISH : COPY;
            end
            FILL: if (abort) begin
                w_state = FINISH;
            end else begin
                w_y_en  = 1'b1;
                w_y_a   = r_dst + w_cnt_lo;
                w_y_di  = r_fill;
                w_cnt   = w_cnt_inc;
                w_state = (w_cnt_inc == r_len) ? FINISH : FILL;
            end
            FINISH: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_x_a   <= '0;
            r_y_a   <= '0;
            r_y_di  <= '0;
            r_x_en  <= 1'b0;
            r_y_en  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_len   <= w_len;
            r_fill  <= w_fill;
            r_cnt   <= w_cnt;
            r_x_a   <= w_x_a;
            r_y_a   <= w_y_a;
            r_y_di  <= w_y_di;
            r_x_en  <= w_x_en;
            r_y_en  <= w_y_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end
    assign RAM_X_EN = r_x_en;
    assign RAM_X_WE = '0;
    assign RAM_X_A  = r_x_a;
    assign RAM_Y_EN = r_y_en;
    assign RAM_Y_WE = {WE_WIDTH{r_y_en}};
    assign RAM_Y_A  = r_y_a;
    assign RAM_Y_Di = r_y_di;
    assign busy     = r_busy;
    assign done     = r_done;
endmodule
